// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
// Radix-4 Booth multiply is selected by defining MULTDIV_BOOTH4_EN.
package multdiv_pkg;

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
   typedef enum logic {OP_MUL, OP_DIV} op_t;

   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/multdiv_booth_step.sv
// One Booth recoding step on the product register {acc, multiplier, q-1}.
// MULTDIV_BOOTH4_EN selects radix-4 (2 bits/step); default is radix-2.
import multdiv_pkg::*;

module multdiv_booth_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH+2:0] prod,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH+2:0] prod_nxt
);

   localparam int AW = WIDTH + 2;

   // Two guard bits keep +/-2M and -MIN_INT exact in the accumulator
   logic [AW-1:0] acc, mx, sum;

   assign acc = prod[2*WIDTH+2:WIDTH+1];
   assign mx  = {{2{mcand[WIDTH-1]}}, mcand};

`ifdef MULTDIV_BOOTH4_EN
   always_comb begin
      sum = acc;
      case (prod[2:0])
         3'b001, 3'b010: sum = acc + mx;
         3'b011:         sum = acc + (mx << 1);
         3'b100:         sum = acc - (mx << 1);
         3'b101, 3'b110: sum = acc - mx;
         default:        sum = acc;
      endcase
   end

   assign prod_nxt = $signed({sum, prod[WIDTH:0]}) >>> 2;
`else
   always_comb begin
      sum = acc;
      case (prod[1:0])
         2'b01:   sum = acc + mx;
         2'b10:   sum = acc - mx;
         default: sum = acc;
      endcase
   end

   assign prod_nxt = $signed({sum, prod[WIDTH:0]}) >>> 1;
`endif

endmodule

// File: rtl/multdiv_seq.sv
// Multicycle signed multiply (Booth) / divide (restoring) unit.
// Define MULTDIV_BOOTH4_EN for radix-4 multiply (WIDTH/2 steps).
import multdiv_pkg::*;

module multdiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = clog2(WIDTH + 1);
`ifdef MULTDIV_BOOTH4_EN
   localparam int MUL_N = WIDTH / 2;
`else
   localparam int MUL_N = WIDTH;
`endif
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   op_t                op;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH+2:0] prod, prod_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   quo, rem, dvsr;
   logic [WIDTH-1:0]   quo_nxt, rem_nxt;
   logic [WIDTH:0]     trial, hi;
   logic               neg, dz, dov;
   logic               start, ge;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign start = ctrl_MULT | ctrl_DIV;
   assign op    = ctrl_MULT ? OP_MUL : OP_DIV;

   // Upper WIDTH+1 bits of the 2*WIDTH product must agree to fit
   assign hi = prod[2*WIDTH:WIDTH];

   assign trial   = {rem, quo[WIDTH-1]};
   assign ge      = trial >= {1'b0, dvsr};
   assign rem_nxt = ge ? trial[WIDTH-1:0] - dvsr : trial[WIDTH-1:0];
   assign quo_nxt = {quo[WIDTH-2:0], ge};

   multdiv_booth_step #(.WIDTH(WIDTH)) u_booth (
      .prod     (prod),
      .mcand    (mcand),
      .prod_nxt (prod_nxt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         prod           <= '0;
         mcand          <= '0;
         quo            <= '0;
         rem            <= '0;
         dvsr           <= '0;
         neg            <= 1'b0;
         dz             <= 1'b0;
         dov            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else if (start) begin
         cnt            <= '0;
         busy           <= 1'b1;
         data_resultRDY <= 1'b0;
         if (op == OP_MUL) begin
            state <= MULT;
            prod  <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
            mcand <= data_operandA;
         end else begin
            state <= DIV;
            quo   <= mag(data_operandA);
            rem   <= '0;
            dvsr  <= mag(data_operandB);
            neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz    <= data_operandB == '0;
            dov   <= (data_operandA == MIN_INT) && (&data_operandB);
         end
      end else begin
         case (state)
            MULT: begin
               if (cnt == CW'(MUL_N)) begin
                  data_result    <= prod[WIDTH:1];
                  data_exception <= ~((&hi) | ~(|hi));
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  state          <= DONE;
               end else begin
                  prod <= prod_nxt;
                  cnt  <= cnt + CW'(1);
               end
            end
            DIV: begin
               if (cnt == CW'(WIDTH)) begin
                  data_result    <= dz ? '0 : (neg ? -quo : quo);
                  data_exception <= dz | dov;
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  state          <= DONE;
               end else begin
                  quo <= quo_nxt;
                  rem <= rem_nxt;
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               data_resultRDY <= 1'b0;
               state          <= IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomised and directed bench for multdiv_seq against an arithmetic model.
// Follows MULTDIV_BOOTH4_EN for the expected multiply latency.
module tb_multdiv_seq;

   localparam int W = 32;
`ifdef MULTDIV_BOOTH4_EN
   localparam int NM = 16;
`else
   localparam int NM = 32;
`endif
   localparam int ND = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  data_operandA = '0;
   logic [W-1:0]  data_operandB = '0;
   logic          ctrl_MULT = 1'b0;
   logic          ctrl_DIV = 1'b0;
   logic [W-1:0]  data_result;
   logic          data_exception;
   logic          data_resultRDY;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   multdiv_seq #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input bit mul, input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] r, output bit e);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint p;
      if (mul) begin
         p = sa * sb;
         r = p[31:0];
         e = p != longint'($signed(r));
      end else if (sb == 0) begin
         r = '0;
         e = 1'b1;
      end else if (sa == -64'sd2147483648 && sb == -1) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = 1'b0;
      end
   endfunction

   task automatic wait_rdy(output int lat, input int lim);
      lat = -1;
      for (int k = 1; k <= lim; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            lat = k;
            return;
         end
      end
   endtask

   task automatic run_op(input string tag, input bit mul, input bit dv,
                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      bit          ee;
      int          lat;
      int          n;
      model(mul, a, b, er, ee);
      n = mul ? NM : ND;
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = mul;
      ctrl_DIV      = dv;
      @(posedge clock);
      #1 check({tag, ".busy"}, 64'(busy), 64'd1);
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      wait_rdy(lat, n + 8);
      check({tag, ".lat"}, 64'(lat), 64'(n + 1));
      check({tag, ".res"}, 64'(data_result), 64'(er));
      check({tag, ".exc"}, 64'(data_exception), 64'(ee));
      check({tag, ".busy0"}, 64'(busy), 64'd0);
      @(posedge clock);
      #1 check({tag, ".rdy1cyc"}, 64'(data_resultRDY), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom & 32'hFFFF;
         6:       return -($urandom & 32'hFFFF);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1);
   end

   initial begin
      int seen;
      int nrdy;
      int lat;
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      bit          m;

      #12;
      check("rst.res", 64'(data_result), 64'd0);
      check("rst.exc", 64'(data_exception), 64'd0);
      check("rst.rdy", 64'(data_resultRDY), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      run_op("mul7x-3", 1, 0, 32'd7, -32'd3);
      run_op("mulovf", 1, 0, 32'h0001_0000, 32'h0001_0000);
      run_op("mulmax", 1, 0, 32'h7FFF_FFFF, 32'd1);
      run_op("div-7/2", 0, 1, -32'd7, 32'd2);
      run_op("div5/0", 0, 1, 32'd5, 32'd0);
      run_op("divmin", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div0/5", 0, 1, 32'd0, -32'd5);

      // restart: MULT 3*4, then DIV 9/3 issued on the tenth edge
      @(negedge clock);
      data_operandA = 32'd3;
      data_operandB = 32'd4;
      ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      seen = 0;
      repeat (9) begin
         @(posedge clock);
         #1 if (data_resultRDY) seen++;
      end
      @(negedge clock);
      data_operandA = 32'd9;
      data_operandB = 32'd3;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      nrdy = 0;
      lat  = -1;
      res  = '0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            nrdy++;
            if (lat < 0) begin
               lat = k;
               res = data_result;
            end
         end
      end
      check("restart.early", 64'(seen), 64'd0);
      check("restart.nrdy", 64'(nrdy), 64'd1);
      check("restart.lat", 64'(lat), 64'd33);
      check("restart.res", 64'(res), 64'd3);

      run_op("both6,2", 1, 1, 32'd6, 32'd2);

      // asynchronous reset in the middle of a divide
      @(negedge clock);
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_DIV = 1'b0;
      repeat (5) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("arst.res", 64'(data_result), 64'd0);
      check("arst.exc", 64'(data_exception), 64'd0);
      check("arst.rdy", 64'(data_resultRDY), 64'd0);
      check("arst.busy", 64'(busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      nrdy = 0;
      repeat (40) begin
         @(posedge clock);
         #1 if (data_resultRDY) nrdy++;
      end
      check("arst.nordy", 64'(nrdy), 64'd0);
      run_op("arst.next", 0, 1, -32'd100, 32'd7);

      for (int i = 0; i < 40; i++) begin
         a = pick();
         b = pick();
         m = 1'($urandom_range(0, 1));
         run_op(m ? "rnd.mul" : "rnd.div", m, !m, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
